// File: rtl/lms_fir_mac.sv
// Adaptive FIR output stage: y[n] = sum w[i]*u[n-i]. A single serial MAC does one tap per cycle.
// Weights arrive from the LMS block into a staging bank and become active only when a sample is accepted.
module lms_fir_mac #(
    parameter int N     = 32,
    parameter int IN_W  = 20,
    parameter int W_W   = 20,
    parameter int OUT_W = 20,
    parameter int R_IN  = 18,
    parameter int R_W   = 18,
    parameter int R_OUT = 18,
    parameter int ACC_W = 48
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    valid_u_in,
    input  logic signed [IN_W-1:0]  data_u_in,
    input  logic                    valid_w_in,
    input  logic [N*W_W-1:0]        data_w_in,
    output logic signed [OUT_W-1:0] data_y_out,
    output logic                    valid_y_out,
    output logic                    busy,
    output logic                    overrun
);

    localparam int PROD_W = IN_W + W_W;
    localparam int S      = R_IN + R_W - R_OUT;
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(64'd1 << (S - 1));
    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((64'd1 << (OUT_W - 1)) - 64'd1);
    localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

    typedef enum logic {IDLE, MAC} state_t;

    state_t                  state_q, state_d;
    logic signed [IN_W-1:0]  x_q     [N];
    logic signed [IN_W-1:0]  x_d     [N];
    logic signed [W_W-1:0]   w_act_q [N];
    logic signed [W_W-1:0]   w_act_d [N];
    logic signed [W_W-1:0]   w_stg_q [N];
    logic signed [W_W-1:0]   w_stg_d [N];
    logic signed [W_W-1:0]   w_in    [N];
    logic signed [W_W-1:0]   w_sel   [N];
    logic                    stg_valid_q, stg_valid_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic signed [OUT_W-1:0] y_q, y_d;
    logic                    valid_y_q, valid_y_d;
    logic                    overrun_q, overrun_d;

    logic signed [W_W-1:0]    op_w;
    logic signed [IN_W-1:0]   op_x;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_base;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  rounded;
    logic signed [OUT_W-1:0]  y_sat;

    // Weight set used at accept: a coincident valid_w_in wins, then a pending staged set, else the current one.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_in[i]  = data_w_in[i*W_W +: W_W];
            w_sel[i] = valid_w_in ? w_in[i] : (stg_valid_q ? w_stg_q[i] : w_act_q[i]);
        end
    end

    always_comb begin
        prod     = op_w * op_x;
        sum      = acc_base + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        rounded  = (sum + HALF) >>> S;
        if (rounded > Y_MAX) begin
            y_sat = Y_MAX[OUT_W-1:0];
        end else if (rounded < Y_MIN) begin
            y_sat = Y_MIN[OUT_W-1:0];
        end else begin
            y_sat = rounded[OUT_W-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        w_act_d     = w_act_q;
        w_stg_d     = w_stg_q;
        stg_valid_d = stg_valid_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        y_d         = y_q;
        valid_y_d   = 1'b0;
        overrun_d   = overrun_q;
        op_w        = w_act_q[idx_q];
        op_x        = x_q[idx_q];
        acc_base    = acc_q;

        if (valid_w_in) begin
            w_stg_d     = w_in;
            stg_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                op_w     = w_sel[0];
                op_x     = data_u_in;
                acc_base = '0;
                if (valid_u_in) begin
                    for (int i = N - 1; i > 0; i--) begin
                        x_d[i] = x_q[i-1];
                    end
                    x_d[0]      = data_u_in;
                    w_act_d     = w_sel;
                    stg_valid_d = 1'b0;
                    acc_d       = sum;
                    if (N == 1) begin
                        y_d       = y_sat;
                        valid_y_d = 1'b1;
                    end else begin
                        idx_d   = IDX_W'(1);
                        state_d = MAC;
                    end
                end
            end
            MAC: begin
                if (valid_u_in) begin
                    overrun_d = 1'b1;
                end
                acc_d = sum;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    y_d       = y_sat;
                    valid_y_d = 1'b1;
                    idx_d     = '0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            x_q         <= '{default: '0};
            w_act_q     <= '{default: '0};
            w_stg_q     <= '{default: '0};
            stg_valid_q <= 1'b0;
            acc_q       <= '0;
            idx_q       <= '0;
            y_q         <= '0;
            valid_y_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            w_act_q     <= w_act_d;
            w_stg_q     <= w_stg_d;
            stg_valid_q <= stg_valid_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            y_q         <= y_d;
            valid_y_q   <= valid_y_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data_y_out  = y_q;
    assign valid_y_out = valid_y_q;
    assign busy        = (state_q == MAC);
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_lms_fir_mac.sv
// Directed bench for lms_fir_mac with default parameters (N=32, Q2.18 data, weights and output).
module tb_lms_fir_mac;

    localparam int N   = 32;
    localparam int W_W = 20;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                valid_u_in = 1'b0;
    logic signed [19:0]  data_u_in = '0;
    logic                valid_w_in = 1'b0;
    logic [N*W_W-1:0]    data_w_in = '0;
    logic signed [19:0]  data_y_out;
    logic                valid_y_out;
    logic                busy;
    logic                overrun;

    int checks = 0;
    int passes = 0;

    lms_fir_mac dut (
        .clock       (clock),
        .reset       (reset),
        .valid_u_in  (valid_u_in),
        .data_u_in   (data_u_in),
        .valid_w_in  (valid_w_in),
        .data_w_in   (data_w_in),
        .data_y_out  (data_y_out),
        .valid_y_out (valid_y_out),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clock = ~clock;

    // All drivers are called on a falling edge and return on a falling edge.
    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic load_w(input logic [N*W_W-1:0] wv);
        valid_w_in = 1'b1;
        data_w_in  = wv;
        @(negedge clock);
        valid_w_in = 1'b0;
    endtask

    task automatic send_sample(input logic signed [19:0] u);
        valid_u_in = 1'b1;
        data_u_in  = u;
        @(negedge clock);
        valid_u_in = 1'b0;
        data_u_in  = '0;
    endtask

    // Returns X on timeout so the caller's comparison fails.
    task automatic wait_result(output logic signed [19:0] y);
        int n = 0;
        while (valid_y_out !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        y = (valid_y_out === 1'b1) ? data_y_out : 'x;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (data_y_out !== 20'sd0) $display("[TB] FAIL reset_y: got %0d want 0", data_y_out); else passes++;
        checks++; if (valid_y_out !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", valid_y_out); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else passes++;
        checks++; if (overrun !== 1'b0) $display("[TB] FAIL reset_overrun: got %b want 0", overrun); else passes++;
    endtask

    task automatic test_zero_weights();
        int cyc;
        int busy_bad;
        do_reset();
        send_sample(20'sd100000);
        cyc = 1;
        busy_bad = 0;
        while (valid_y_out !== 1'b1 && cyc < 100) begin
            if (busy !== 1'b1) busy_bad++;
            @(negedge clock);
            cyc++;
        end
        checks++; if (cyc != 32) $display("[TB] FAIL zero_latency: got %0d want 32", cyc); else passes++;
        checks++; if (busy_bad != 0) $display("[TB] FAIL zero_busy: %0d idle cycles during MAC, want 0", busy_bad); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL zero_busy_end: got %b want 0", busy); else passes++;
        checks++; if (data_y_out !== 20'sd0) $display("[TB] FAIL zero_y: got %0d want 0", data_y_out); else passes++;
    endtask

    task automatic test_impulse();
        logic [N*W_W-1:0]   wv;
        logic signed [19:0] y;
        logic signed [19:0] exp_y [4];
        logic signed [19:0] u_seq [4];
        exp_y = '{20'sd0, 20'sd0, 20'sd0, 20'sd32768};
        u_seq = '{20'sd131072, 20'sd0, 20'sd0, 20'sd0};
        do_reset();
        wv = '0;
        wv[0 +: W_W] = 20'd262144;
        load_w(wv);
        send_sample(20'sd131072);
        wait_result(y);
        checks++; if (y !== 20'sd131072) $display("[TB] FAIL impulse_w0: got %0d want 131072", y); else passes++;
        do_reset();
        wv = '0;
        wv[3*W_W +: W_W] = 20'd65536;
        load_w(wv);
        for (int k = 0; k < 4; k++) begin
            send_sample(u_seq[k]);
            wait_result(y);
            checks++;
            if (y !== exp_y[k]) $display("[TB] FAIL impulse_w3_%0d: got %0d want %0d", k, y, exp_y[k]);
            else passes++;
        end
    endtask

    task automatic test_saturation();
        logic [N*W_W-1:0]   wv;
        logic signed [19:0] y;
        for (int i = 0; i < N; i++) wv[i*W_W +: W_W] = 20'd262144;
        do_reset();
        load_w(wv);
        for (int k = 0; k < N; k++) begin
            send_sample(20'sd524287);
            wait_result(y);
        end
        checks++; if (y !== 20'sd524287) $display("[TB] FAIL sat_pos: got %0d want 524287", y); else passes++;
        do_reset();
        load_w(wv);
        for (int k = 0; k < N; k++) begin
            send_sample(-20'sd524288);
            wait_result(y);
        end
        checks++; if (y !== -20'sd524288) $display("[TB] FAIL sat_neg: got %0d want -524288", y); else passes++;
    endtask

    task automatic test_rounding();
        logic [N*W_W-1:0]   wv;
        logic signed [19:0] y;
        do_reset();
        wv = '0;
        wv[0 +: W_W] = 20'd1;
        load_w(wv);
        send_sample(20'sd131072);
        wait_result(y);
        checks++; if (y !== 20'sd1) $display("[TB] FAIL round_pos_half: got %0d want 1", y); else passes++;
        send_sample(-20'sd131072);
        wait_result(y);
        checks++; if (y !== 20'sd0) $display("[TB] FAIL round_neg_half: got %0d want 0", y); else passes++;
    endtask

    task automatic test_weight_update();
        logic [N*W_W-1:0]   wv;
        logic signed [19:0] y;
        wv = '0;
        wv[0 +: W_W] = 20'd262144;
        do_reset();
        send_sample(20'sd100000);
        repeat (9) @(negedge clock);
        load_w(wv);
        wait_result(y);
        checks++; if (y !== 20'sd0) $display("[TB] FAIL wupd_old_weight: got %0d want 0", y); else passes++;
        send_sample(20'sd50000);
        wait_result(y);
        checks++; if (y !== 20'sd50000) $display("[TB] FAIL wupd_new_weight: got %0d want 50000", y); else passes++;
        do_reset();
        valid_w_in = 1'b1;
        data_w_in  = wv;
        valid_u_in = 1'b1;
        data_u_in  = 20'sd70000;
        @(negedge clock);
        valid_w_in = 1'b0;
        valid_u_in = 1'b0;
        data_u_in  = '0;
        wait_result(y);
        checks++; if (y !== 20'sd70000) $display("[TB] FAIL wupd_bypass: got %0d want 70000", y); else passes++;
    endtask

    task automatic test_overrun();
        logic [N*W_W-1:0]   wv;
        logic signed [19:0] y;
        wv = '0;
        wv[0 +: W_W]   = 20'd262144;
        wv[W_W +: W_W] = 20'd131072;
        do_reset();
        load_w(wv);
        send_sample(20'sd100000);
        wait_result(y);
        checks++; if (y !== 20'sd100000) $display("[TB] FAIL ovr_first: got %0d want 100000", y); else passes++;
        send_sample(20'sd40000);
        repeat (4) @(negedge clock);
        send_sample(20'sd77777);
        checks++; if (overrun !== 1'b1) $display("[TB] FAIL ovr_flag: got %b want 1", overrun); else passes++;
        wait_result(y);
        checks++; if (y !== 20'sd90000) $display("[TB] FAIL ovr_running_y: got %0d want 90000", y); else passes++;
        send_sample(20'sd20000);
        wait_result(y);
        checks++; if (y !== 20'sd40000) $display("[TB] FAIL ovr_unshifted: got %0d want 40000", y); else passes++;
        checks++; if (overrun !== 1'b1) $display("[TB] FAIL ovr_sticky: got %b want 1", overrun); else passes++;
    endtask

    // Runs straight after test_overrun so y and overrun are nonzero going in.
    task automatic test_reset_mid_mac();
        int seen = 0;
        send_sample(20'sd1000);
        repeat (19) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++; if (data_y_out !== 20'sd0) $display("[TB] FAIL midrst_y: got %0d want 0", data_y_out); else passes++;
        checks++; if (valid_y_out !== 1'b0) $display("[TB] FAIL midrst_valid: got %b want 0", valid_y_out); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL midrst_busy: got %b want 0", busy); else passes++;
        checks++; if (overrun !== 1'b0) $display("[TB] FAIL midrst_overrun: got %b want 0", overrun); else passes++;
        for (int k = 0; k < 40; k++) begin
            if (valid_y_out !== 1'b0) seen++;
            @(negedge clock);
        end
        checks++; if (seen != 0) $display("[TB] FAIL midrst_no_output: got %0d valid cycles want 0", seen); else passes++;
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_zero_weights();
        test_impulse();
        test_saturation();
        test_rounding();
        test_weight_update();
        test_overrun();
        test_reset_mid_mac();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
